// File: rtl/multicycle_control.sv
// multicycle_control: FSM control unit for the multicycle ARM-subset datapath (BR 3, DP 4, STR 4, LDR 5 cycles).
// Optional MULTICYCLE_CTRL_MEM_WAIT_EN: FETCH/MEMRD/MEMWR stall until mem_ready, re-asserting their strobes.
module multicycle_control #(
  parameter int ALU_CTRL_W = 2,
  parameter int FLAG_W     = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            op,
  input  logic [5:0]            funct,
  input  logic [3:0]            cond,
  input  logic [3:0]            rd,
  input  logic [FLAG_W-1:0]     alu_flag,
`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
  input  logic                  mem_ready,
`endif
  output logic                  pc_write,
  output logic                  adr_src,
  output logic                  ir_write,
  output logic                  mem_write,
  output logic                  reg_write,
  output logic [1:0]            result_src,
  output logic                  alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [1:0]            imm_src,
  output logic [1:0]            reg_src,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic                  shift,
  output logic [FLAG_W-1:0]     flags
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH
  } state_t;

  localparam bit EXT_ALU = (ALU_CTRL_W >= 3);

  state_t      state_q, state_d;
  logic [3:0]  flags_q;
  logic        cond_ex_q;
  logic        mem_go;
  logic [3:0]  cmd;
  logic        no_write, supported, cv_upd, flag_we;
  logic [2:0]  alu3;
  logic [1:0]  reg_src_dec;

`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
  assign mem_go = mem_ready;
`else
  assign mem_go = 1'b1;
`endif

  assign cmd         = funct[4:1];
  assign no_write    = (cmd == 4'b1010) || (cmd == 4'b1000);
  assign reg_src_dec = {(op == 2'b01) && !funct[0], op == 2'b10};
  assign flags       = FLAG_W'(flags_q);

  function automatic logic cond_check(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'h0: cond_check = z;
      4'h1: cond_check = !z;
      4'h2: cond_check = cy;
      4'h3: cond_check = !cy;
      4'h4: cond_check = n;
      4'h5: cond_check = !n;
      4'h6: cond_check = v;
      4'h7: cond_check = !v;
      4'h8: cond_check = cy && !z;
      4'h9: cond_check = !cy || z;
      4'hA: cond_check = (n == v);
      4'hB: cond_check = (n != v);
      4'hC: cond_check = !z && (n == v);
      4'hD: cond_check = z || (n != v);
      4'hE: cond_check = 1'b1;
      default: cond_check = 1'b0;
    endcase
  endfunction

  // Unsupported commands fall back to ADD and leave the flags alone.
  always_comb begin
    alu3      = 3'd0;
    supported = 1'b1;
    cv_upd    = 1'b0;
    case (cmd)
      4'b0100: cv_upd = 1'b1;
      4'b0010: begin alu3 = 3'd1; cv_upd = 1'b1; end
      4'b1010: begin alu3 = 3'd1; cv_upd = 1'b1; end
      4'b0000: alu3 = 3'd2;
      4'b1000: alu3 = 3'd2;
      4'b1100: alu3 = 3'd3;
      4'b0001: begin alu3 = EXT_ALU ? 3'd4 : 3'd0; supported = EXT_ALU; end
      4'b1101: begin alu3 = EXT_ALU ? 3'd5 : 3'd0; supported = EXT_ALU; end
      default: supported = 1'b0;
    endcase
  end

  assign flag_we = ((state_q == EXECR) || (state_q == EXECI)) &&
                   (funct[0] || no_write) && cond_ex_q && supported;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH;
      flags_q   <= 4'b0000;
      cond_ex_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == DECODE)
        cond_ex_q <= cond_check(cond, flags_q);
      if (flag_we)
        flags_q <= {alu_flag[3:2], cv_upd ? alu_flag[1:0] : flags_q[1:0]};
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_write    = 1'b0;
    adr_src     = 1'b0;
    ir_write    = 1'b0;
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    imm_src     = 2'b00;
    reg_src     = 2'b00;
    alu_control = '0;
    shift       = 1'b0;
    // Operands come from the held IR once the fetch is done.
    if (state_q != FETCH)
      reg_src = reg_src_dec;
    case (state_q)
      FETCH: begin
        ir_write   = 1'b1;
        pc_write   = 1'b1;
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (mem_go) state_d = DECODE;
      end
      DECODE: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        case (op)
          2'b00:   state_d = funct[5] ? EXECI : EXECR;
          2'b01:   state_d = MEMADR;
          2'b10:   state_d = BRANCH;
          default: state_d = FETCH;
        endcase
      end
      MEMADR: begin
        alu_src_b = 2'b01;
        imm_src   = op;
        state_d   = funct[0] ? MEMRD : MEMWR;
      end
      MEMRD: begin
        adr_src = 1'b1;
        if (mem_go) state_d = MEMWB;
      end
      MEMWB: begin
        result_src = 2'b01;
        if (rd == 4'hF) pc_write = cond_ex_q;
        else            reg_write = cond_ex_q;
        state_d = FETCH;
      end
      MEMWR: begin
        adr_src   = 1'b1;
        mem_write = cond_ex_q;
        if (mem_go) state_d = FETCH;
      end
      EXECR: begin
        alu_control = ALU_CTRL_W'(alu3);
        shift       = (cmd == 4'b1101);
        state_d     = ALUWB;
      end
      EXECI: begin
        alu_src_b   = 2'b01;
        imm_src     = op;
        alu_control = ALU_CTRL_W'(alu3);
        state_d     = ALUWB;
      end
      ALUWB: begin
        if (!no_write) begin
          if (rd == 4'hF) pc_write = cond_ex_q;
          else            reg_write = cond_ex_q;
        end
        state_d = FETCH;
      end
      BRANCH: begin
        alu_src_b  = 2'b01;
        imm_src    = op;
        result_src = 2'b10;
        pc_write   = cond_ex_q;
        state_d    = FETCH;
      end
      default: state_d = FETCH;
    endcase
    if (reset) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction expected control vectors are queued, then popped each cycle.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] cond, rd, alu_flag;
  logic       pc_write, adr_src, ir_write, mem_write, reg_write, alu_src_a, shift;
  logic [1:0] result_src, alu_src_b, imm_src, reg_src, alu_control;
  logic [3:0] flags;
`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
  logic       mem_ready = 1'b1;
`endif

  always #5 clk = ~clk;

  multicycle_control #(.ALU_CTRL_W(2), .FLAG_W(4)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .cond(cond), .rd(rd),
    .alu_flag(alu_flag),
`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
    .mem_ready(mem_ready),
`endif
    .pc_write(pc_write), .adr_src(adr_src), .ir_write(ir_write),
    .mem_write(mem_write), .reg_write(reg_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
    .reg_src(reg_src), .alu_control(alu_control), .shift(shift), .flags(flags)
  );

  typedef struct packed {
    logic       pcw, adr, irw, memw, regw;
    logic [1:0] res;
    logic       asa;
    logic [1:0] asb, imm, rsrc, aluc;
    logic       sh;
    logic [3:0] fl;
  } obs_t;

  typedef struct packed {
    obs_t       o;
    logic       rdy;
    logic [3:0] st;
  } item_t;

  localparam logic [3:0] S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3, S_MEMWB = 4,
                         S_MEMWR = 5, S_EXECR = 6, S_EXECI = 7, S_ALUWB = 8, S_BRANCH = 9;
  string st_name [10] = '{"fetch", "decode", "memadr", "memrd", "memwb",
                          "memwr", "execr", "execi", "aluwb", "branch"};

  item_t      q[$];
  logic [3:0] mflags;
  int         n_tests = 0;
  int         n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic obs_t sample();
    obs_t o;
    o = {pc_write, adr_src, ir_write, mem_write, reg_write, result_src, alu_src_a,
         alu_src_b, imm_src, reg_src, alu_control, shift, flags};
    return o;
  endfunction

  function automatic logic condok(input logic [3:0] c, input logic [3:0] f);
    case (c)
      4'h0: return f[2];
      4'h1: return !f[2];
      4'h2: return f[1];
      4'h3: return !f[1];
      4'h4: return f[3];
      4'h5: return !f[3];
      4'h6: return f[0];
      4'h7: return !f[0];
      4'h8: return f[1] && !f[2];
      4'h9: return !f[1] || f[2];
      4'hA: return f[3] == f[0];
      4'hB: return f[3] != f[0];
      4'hC: return !f[2] && (f[3] == f[0]);
      4'hD: return f[2] || (f[3] != f[0]);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Memory-phase entries get wt stalled copies when the wait feature is built in.
  task automatic push(input obs_t o, input logic [3:0] st, input int wt);
`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
    for (int i = 0; i < wt; i++) q.push_back({o, 1'b0, st});
`endif
    q.push_back({o, 1'b1, st});
  endtask

  task automatic model_instr(input logic [31:0] ins, input logic [3:0] af, input int wt);
    logic [1:0] opi, rs, ac;
    logic [5:0] fn;
    logic [3:0] cm, rdi;
    logic       ce, nw, sup, cv;
    obs_t       o;
    opi = ins[27:26]; fn = ins[25:20]; cm = fn[4:1]; rdi = ins[15:12];
    rs  = {opi == 2'b01 && !fn[0], opi == 2'b10};
    o = '0; o.pcw = 1; o.irw = 1; o.asa = 1; o.asb = 2'b10; o.res = 2'b10; o.fl = mflags;
    push(o, S_FETCH, wt);
    o = '0; o.asa = 1; o.asb = 2'b10; o.rsrc = rs; o.fl = mflags;
    push(o, S_DECODE, 0);
    ce = condok(ins[31:28], mflags);
    case (opi)
      2'b01: begin
        o = '0; o.asb = 2'b01; o.imm = opi; o.rsrc = rs; o.fl = mflags;
        push(o, S_MEMADR, 0);
        o = '0; o.adr = 1; o.rsrc = rs; o.fl = mflags;
        if (fn[0]) begin
          push(o, S_MEMRD, wt);
          o = '0; o.res = 2'b01; o.rsrc = rs; o.fl = mflags;
          if (rdi == 4'hF) o.pcw = ce; else o.regw = ce;
          push(o, S_MEMWB, 0);
        end else begin
          o.memw = ce;
          push(o, S_MEMWR, wt);
        end
      end
      2'b00: begin
        nw = (cm == 4'b1010) || (cm == 4'b1000);
        case (cm)
          4'b0100: {sup, cv, ac} = {1'b1, 1'b1, 2'd0};
          4'b0010: {sup, cv, ac} = {1'b1, 1'b1, 2'd1};
          4'b1010: {sup, cv, ac} = {1'b1, 1'b1, 2'd1};
          4'b0000: {sup, cv, ac} = {1'b1, 1'b0, 2'd2};
          4'b1000: {sup, cv, ac} = {1'b1, 1'b0, 2'd2};
          4'b1100: {sup, cv, ac} = {1'b1, 1'b0, 2'd3};
          default: {sup, cv, ac} = {1'b0, 1'b0, 2'd0};
        endcase
        o = '0; o.asb = fn[5] ? 2'b01 : 2'b00; o.imm = fn[5] ? opi : 2'b00; o.aluc = ac;
        o.sh = !fn[5] && (cm == 4'b1101); o.rsrc = rs; o.fl = mflags;
        push(o, fn[5] ? S_EXECI : S_EXECR, 0);
        if ((fn[0] || nw) && ce && sup)
          mflags = {af[3:2], cv ? af[1:0] : mflags[1:0]};
        o = '0; o.rsrc = rs; o.fl = mflags;
        if (!nw) begin
          if (rdi == 4'hF) o.pcw = ce; else o.regw = ce;
        end
        push(o, S_ALUWB, 0);
      end
      2'b10: begin
        o = '0; o.asb = 2'b01; o.imm = opi; o.res = 2'b10; o.pcw = ce; o.rsrc = rs; o.fl = mflags;
        push(o, S_BRANCH, 0);
      end
      default: ;
    endcase
  endtask

  // Called just after a falling edge; samples each cycle #1 later.
  task automatic run_instr(input logic [31:0] ins, input logic [3:0] af, input int wt,
                           input int abort_at);
    item_t it;
    obs_t  exp;
    int    k;
    {cond, op, funct} = ins[31:20];
    rd       = ins[15:12];
    alu_flag = af;
    model_instr(ins, af, wt);
    k = 0;
    while (q.size() > 0) begin
      it = q.pop_front();
`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
      mem_ready = it.rdy;
`endif
      if (k == abort_at) reset = 1'b1;
      #1;
      exp = it.o;
      if (reset) {exp.pcw, exp.irw, exp.memw, exp.regw} = 4'b0000;
      check_eq($sformatf("%s@%h", st_name[it.st], ins), 32'(sample()), 32'(exp));
      @(negedge clk);
      if (reset) begin
        reset  = 1'b0;
        mflags = 4'b0000;
        q.delete();
        check_eq("flags_after_reset", 32'(flags), 32'h0);
      end
      k++;
    end
`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
    mem_ready = 1'b1;
`endif
  endtask

  initial begin
    obs_t r;
    reset = 1'b1; op = 0; funct = 0; cond = 0; rd = 0; alu_flag = 4'hF; mflags = 4'b0000;
    repeat (3) @(negedge clk);
    #1;
    r = '0; r.asa = 1; r.asb = 2'b10; r.res = 2'b10;
    check_eq("reset_state", 32'(sample()), 32'(r));
    @(negedge clk);
    reset = 1'b0;
    run_instr(32'hE2821005, 4'b0000, 0, -1);  // ADD R1,R2,#5
    run_instr(32'hE0500000, 4'b0110, 0, -1);  // SUBS R0,R0,R0 -> Z,C
    run_instr(32'h0A000002, 4'b0000, 0, -1);  // BEQ taken
    run_instr(32'hE2933000, 4'b0000, 0, -1);  // ADDS clears flags
    run_instr(32'h0A000002, 4'b0000, 0, -1);  // BEQ not taken
    run_instr(32'hE591F000, 4'b0000, 2, -1);  // LDR R15,[R1]
    run_instr(32'hE0500000, 4'b0110, 0, -1);  // SUBS -> Z,C
    run_instr(32'h15812000, 4'b0000, 0, -1);  // STRNE suppressed
    run_instr(32'hE5812000, 4'b0000, 1, -1);  // STR AL
    run_instr(32'hE1110002, 4'b1001, 0, -1);  // TST: N,Z only
    run_instr(32'hE3510001, 4'b0011, 0, -1);  // CMP: all flags, no write
    run_instr(32'hE1A04005, 4'b0000, 0, -1);  // MOV R4,R5 (shift)
    run_instr(32'hE1B04005, 4'b0100, 0, -1);  // MOVS: no flag change at W=2
    run_instr(32'hE2F11005, 4'b1111, 0, -1);  // unsupported cmd 0111 with S
    run_instr(32'hF0821005, 4'b0000, 0, -1);  // cond NV
    run_instr(32'hE0A1F002, 4'b0000, 0, -1);  // ADC-like cmd to R15: ADD, pc write
    run_instr(32'hEC000000, 4'b0000, 0, -1);  // op 11
    run_instr(32'hE591F000, 4'b0000, 0, 2);   // LDR aborted by reset in MEMADR
    run_instr(32'hE2821005, 4'b0000, 3, -1);  // ADD after reset, fetch stall
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, limit 200000 required");
    $fatal(1, "timeout");
  end

endmodule
